// File: rtl/wb_pkg.sv
// Shared types and widths for the cache write-back buffer.
package wb_pkg;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned LINE_W   = 64;
  localparam int unsigned LINE_OFS = 3;
  localparam int unsigned TAG_W    = ADDR_W - LINE_OFS;

  typedef enum logic [1:0] {
    StIdle,
    StAddr,
    StResp
  } issue_state_e;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [LINE_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_cam_fifo.sv
// Circular line store with tag match for coalescing writes and answering read-miss snoops.
module wb_cam_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [TAG_W-1:0]  push_tag,
  input  logic [LINE_W-1:0] push_data,
  input  logic              pop,
  input  logic [TAG_W-1:0]  snoop_tag,
  output logic              full,
  output logic              empty,
  output logic [TAG_W-1:0]  head_tag,
  output logic [LINE_W-1:0] head_data,
  output logic              snoop_hit,
  output logic [LINE_W-1:0] snoop_data
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned PtrW = IdxW + 1;

  wb_entry_t       entries_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [IdxW-1:0] wr_idx, rd_idx;
  logic            coal_hit;
  logic [IdxW-1:0] coal_idx;
  logic            newer_hit;
  logic [IdxW-1:0] newer_idx;
  logic            head_hit;

  assign wr_idx    = wr_ptr_q[IdxW-1:0];
  assign rd_idx    = rd_ptr_q[IdxW-1:0];
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[PtrW-1] != rd_ptr_q[PtrW-1]) && (wr_idx == rd_idx);
  assign head_tag  = entries_q[rd_idx].tag;
  assign head_data = entries_q[rd_idx].data;

  // The head is excluded: whenever it is valid it is either issued or being latched this cycle.
  always_comb begin
    coal_hit = 1'b0;
    coal_idx = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (entries_q[i].valid && entries_q[i].tag == push_tag && IdxW'(i) != rd_idx) begin
        coal_hit = 1'b1;
        coal_idx = IdxW'(i);
      end
    end
  end

  // At most one non-head entry can match a line, and it is newer than the head.
  always_comb begin
    newer_hit  = 1'b0;
    newer_idx  = '0;
    head_hit   = entries_q[rd_idx].valid && (entries_q[rd_idx].tag == snoop_tag);
    snoop_hit  = 1'b0;
    snoop_data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (entries_q[i].valid && entries_q[i].tag == snoop_tag && IdxW'(i) != rd_idx) begin
        newer_hit = 1'b1;
        newer_idx = IdxW'(i);
      end
    end
    if (newer_hit) begin
      snoop_hit  = 1'b1;
      snoop_data = entries_q[newer_idx].data;
    end else if (head_hit) begin
      snoop_hit  = 1'b1;
      snoop_data = entries_q[rd_idx].data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entries_q[i].valid <= 1'b0;
      end
    end else begin
      if (push && coal_hit) begin
        entries_q[coal_idx].data <= push_data;
      end else if (push) begin
        entries_q[wr_idx] <= '{valid: 1'b1, tag: push_tag, data: push_data};
        wr_ptr_q          <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        entries_q[rd_idx].valid <= 1'b0;
        rd_ptr_q                <= rd_ptr_q + PtrW'(1);
      end
    end
  end

endmodule

// File: rtl/write_buffer.sv
// Write-back buffer top: queues evicted lines and issues them one at a time to main memory.
module write_buffer
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [LINE_W-1:0] wb_data,
  input  logic [ADDR_W-1:0] snoop_addr,
  output logic              snoop_hit,
  output logic [LINE_W-1:0] snoop_data,
  output logic              awvalid,
  output logic [ADDR_W-1:0] awaddr,
  output logic [LINE_W-1:0] wdata,
  input  logic              awready,
  input  logic              bvalid,
  output logic              empty,
  output logic              full
);

  issue_state_e      state_q, state_d;
  logic              push, pop;
  logic              fifo_full, fifo_empty;
  logic [TAG_W-1:0]  head_tag;
  logic [LINE_W-1:0] head_data;
  logic [ADDR_W-1:0] awaddr_q;
  logic [LINE_W-1:0] wdata_q;
  logic              unused_offset_bits;

  assign unused_offset_bits = ^{wb_addr[LINE_OFS-1:0], snoop_addr[LINE_OFS-1:0]};

  assign wb_ready = !fifo_full;
  assign push     = wb_valid && wb_ready;
  assign empty    = fifo_empty;
  assign full     = fifo_full;
  assign awaddr   = awaddr_q;
  assign wdata    = wdata_q;

  wb_cam_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_tag  (wb_addr[ADDR_W-1:LINE_OFS]),
    .push_data (wb_data),
    .pop       (pop),
    .snoop_tag (snoop_addr[ADDR_W-1:LINE_OFS]),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head_tag  (head_tag),
    .head_data (head_data),
    .snoop_hit (snoop_hit),
    .snoop_data(snoop_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (!fifo_empty) state_d = StAddr;
      StAddr:  if (awready) state_d = StResp;
      StResp:  if (bvalid) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    awvalid = (state_q == StAddr);
    pop     = (state_q == StResp) && bvalid;
  end

  // Request registers are loaded only when leaving IDLE, so they hold through ADDR and RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      awaddr_q <= '0;
      wdata_q  <= '0;
    end else if (state_q == StIdle && !fifo_empty) begin
      awaddr_q <= {head_tag, {LINE_OFS{1'b0}}};
      wdata_q  <= head_data;
    end
  end

endmodule

// File: tb/tb_write_buffer.sv
// Directed bench for write_buffer: memory writes are checked by a scoreboard monitor.
module tb_write_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_addr;
  logic [63:0] wb_data;
  logic [31:0] snoop_addr;
  logic        snoop_hit;
  logic [63:0] snoop_data;
  logic        awvalid;
  logic [31:0] awaddr;
  logic [63:0] wdata;
  logic        awready;
  logic        bvalid;
  logic        empty;
  logic        full;
  logic        auto_b;

  typedef struct {
    logic [31:0] a;
    logic [63:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  write_buffer #(
    .DEPTH(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wb_valid  (wb_valid),
    .wb_ready  (wb_ready),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .snoop_addr(snoop_addr),
    .snoop_hit (snoop_hit),
    .snoop_data(snoop_data),
    .awvalid   (awvalid),
    .awaddr    (awaddr),
    .wdata     (wdata),
    .awready   (awready),
    .bvalid    (bvalid),
    .empty     (empty),
    .full      (full)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic expect_write(input logic [31:0] a, input logic [63:0] d);
    exp_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic wr(input logic [31:0] a, input logic [63:0] d);
    wb_valid = 1'b1;
    wb_addr  = a;
    wb_data  = d;
    @(posedge clk);
    #1;
    wb_valid = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    int k = 0;
    while (!empty && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    check(name, {127'd0, empty}, 128'd1);
  endtask

  task automatic check_reset_state(input string name);
    check({name, "_flags"}, {123'd0, awvalid, snoop_hit, empty, full, wb_ready}, 128'b00101);
    check({name, "_aw"}, {awaddr, wdata}, 128'd0);
    check({name, "_snoop_data"}, {64'd0, snoop_data}, 128'd0);
  endtask

  // Scoreboard monitor: every accepted memory write must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && awvalid && awready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL mem_write_extra: got addr %h data %h, required no write", awaddr, wdata);
        end else begin
          e = exp_q.pop_front();
          check("mem_write", {32'd0, awaddr, wdata}, {32'd0, e.a, e.d});
        end
      end
    end
  end

  // Memory responder: one-cycle bvalid in the cycle after each accepted request.
  initial begin
    forever begin
      @(negedge clk);
      if (auto_b && !rst && awvalid && awready) begin
        @(posedge clk);
        #1 bvalid = 1'b1;
        @(posedge clk);
        #1 bvalid = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst        = 1'b1;
    wb_valid   = 1'b0;
    wb_addr    = '0;
    wb_data    = '0;
    snoop_addr = '0;
    awready    = 1'b0;
    bvalid     = 1'b0;
    auto_b     = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_state("reset");

    // Single line, immediate handshake.
    awready = 1'b1;
    expect_write(32'h0000_1008, 64'hA5A5_A5A5_0000_0001);
    wr(32'h0000_1008, 64'hA5A5_A5A5_0000_0001);
    @(negedge clk);
    check("t1_idle_awvalid", {127'd0, awvalid}, 128'd0);
    @(negedge clk);
    check("t1_addr_awvalid", {127'd0, awvalid}, 128'd1);
    @(negedge clk);
    check("t1_resp_state", {126'd0, awvalid, empty}, 128'b00);
    @(posedge clk);
    #1;
    check("t1_empty_after_3", {127'd0, empty}, 128'd1);

    // Fill with the memory stalled, then drain across the pointer wrap.
    awready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      expect_write(32'h3000 + 32'(i * 8), 64'hD000_0000_0000_0000 + 64'(i));
      wr(32'h3000 + 32'(i * 8), 64'hD000_0000_0000_0000 + 64'(i));
    end
    check("t2_full", {126'd0, full, wb_ready}, 128'b10);
    snoop_addr = 32'h3010;
    #1;
    check("t2_snoop_mid", {63'd0, snoop_hit, snoop_data}, {64'd1, 64'hD000_0000_0000_0002});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t2_stall_hold", {31'd0, awvalid, awaddr, wdata},
            {32'd1, 32'h3000, 64'hD000_0000_0000_0000});
    end
    @(posedge clk);
    #1 awready = 1'b1;
    wait_empty("t2_drained");
    check("t2_queue_empty", 128'(exp_q.size()), 128'd0);

    // Coalescing behind an issued head.
    awready = 1'b0;
    expect_write(32'h1F00, 64'h1111_0000_0000_00FF);
    wr(32'h1F00, 64'h1111_0000_0000_00FF);
    @(posedge clk);
    #1;
    expect_write(32'h2000, 64'hD2D2_D2D2_D2D2_D2D2);
    wr(32'h2000, 64'hD1D1_D1D1_D1D1_D1D1);
    wr(32'h2000, 64'hD2D2_D2D2_D2D2_D2D2);
    snoop_addr = 32'h0000_2004;
    #1;
    check("t3_snoop_pending", {63'd0, snoop_hit, snoop_data}, {64'd1, 64'hD2D2_D2D2_D2D2_D2D2});
    expect_write(32'h2100, 64'h6161_6161_6161_6161);
    wr(32'h2100, 64'h6161_6161_6161_6161);
    check("t3_occupancy3_not_full", {127'd0, full}, 128'd0);
    expect_write(32'h2200, 64'h6262_6262_6262_6262);
    wr(32'h2200, 64'h6262_6262_6262_6262);
    check("t3_occupancy4_full", {127'd0, full}, 128'd1);
    awready = 1'b1;
    begin
      int k = 0;
      @(negedge clk);
      while (!(awvalid && awaddr == 32'h2000) && k < 30) begin
        @(negedge clk);
        k++;
      end
      check("t3_head_issue_seen", {127'd0, awvalid}, 128'd1);
      check("t3_snoop_head", {63'd0, snoop_hit, snoop_data}, {64'd1, 64'hD2D2_D2D2_D2D2_D2D2});
    end
    @(posedge clk);
    #1;
    wait_empty("t3_drained");
    check("t3_snoop_after_pop", {63'd0, snoop_hit, snoop_data}, 128'd0);

    // A write matching the issued head enqueues a newer entry, which wins the snoop.
    awready = 1'b0;
    expect_write(32'h4000, 64'hE1E1_0000_0000_0001);
    expect_write(32'h4000, 64'hE2E2_0000_0000_0002);
    wr(32'h4000, 64'hE1E1_0000_0000_0001);
    @(posedge clk);
    #1;
    wr(32'h4000, 64'hE2E2_0000_0000_0002);
    snoop_addr = 32'h4000;
    #1;
    check("t4_snoop_newer", {63'd0, snoop_hit, snoop_data}, {64'd1, 64'hE2E2_0000_0000_0002});
    awready = 1'b1;
    wait_empty("t4_drained");
    check("t4_queue_empty", 128'(exp_q.size()), 128'd0);

    // Reset while a request is outstanding, then a stray response.
    awready = 1'b0;
    auto_b  = 1'b0;
    wr(32'h5008, 64'hF0F0_F0F0_F0F0_F0F0);
    @(posedge clk);
    #1;
    snoop_addr = 32'h5008;
    #1;
    check("t5_in_addr", {126'd0, awvalid, snoop_hit}, 128'b11);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    bvalid = 1'b1;
    @(posedge clk);
    #1 bvalid = 1'b0;
    check_reset_state("t5_after_reset");
    @(posedge clk);
    #1;
    check("t5_stays_idle", {126'd0, awvalid, empty}, 128'b01);

    check("final_queue_empty", 128'(exp_q.size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/write_buffer.md
# write_buffer

Cache-side write-back buffer for evicted 64-bit lines headed to main memory. This is the write-direction counterpart of the existing read fill path from the cache controller to main memory. It queues dirty lines from the cache controller and issues them one at a time to main memory over an address/data/response handshake. It also answers same-line snoops from the cache read-miss path so that stale data is never fetched while a write is pending.

## Interface
- `ADDR_W`, 32, byte address width
- `LINE_W`, 64, line (data) width
- `DEPTH`, 4, buffer entries; power of two, ≥2
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `wb_valid`  in  1  cache offers an evicted line
- `wb_ready`  out  1  buffer can accept; equals `!full`
- `wb_addr`  in  ADDR_W  line address; bits [2:0] ignored
- `wb_data`  in  LINE_W  line data
- `snoop_addr`  in  ADDR_W  read-miss address from the cache
- `snoop_hit`  out  1  a buffered entry matches `snoop_addr[ADDR_W-1:3]`
- `snoop_data`  out  LINE_W  data of the matching entry; 0 when no hit
- `awvalid`  out  1  write request to main memory
- `awaddr`  out  ADDR_W  write address, bits [2:0] forced to 0
- `wdata`  out  LINE_W  write data
- `awready`  in  1  memory accepts the request
- `bvalid`  in  1  memory write-complete response (1-cycle pulse)
- `empty`, `full`  out  1  occupancy status

## Operation
- Circular FIFO. Read and write pointers are log2(DEPTH)+1 bits wide. `full` = MSBs differ and the remaining bits are equal. `empty` = pointers are equal.
- Enqueue on `wb_valid && wb_ready`.
- Coalescing: if `wb_addr[ADDR_W-1:3]` matches a valid entry that is not the issued head, overwrite that entry's data in place. No enqueue occurs and the pointers are unchanged.
  - A match against the issued head enqueues a new entry.
  - Result: at most one unissued entry exists per line.
- Snoop is combinational over registered entries only (no bypass of same-cycle `wb_data`).
  - If both the issued head and a newer entry match, the newer entry wins.
- Issue FSM, states IDLE, ADDR, RESP:
  - IDLE: if `!empty`, latch head into `awaddr`/`wdata` and go to ADDR.
  - ADDR: `awvalid`=1. `awaddr`/`wdata` are held stable. On `awready`, go to RESP.
  - RESP: `awvalid`=0. On `bvalid`, pop the head (read pointer +1) and go to IDLE.
  - `bvalid` in IDLE or ADDR is ignored.
- Pointer wrap is modulo 2·DEPTH and is handled naturally by the extra bit.

## Timing
- Reset values: `awvalid`=0, `awaddr`=0, `wdata`=0, `snoop_hit`=0, `snoop_data`=0, `empty`=1, `full`=0, `wb_ready`=1, state=IDLE. Entry valid bits are cleared.
- Reset mid-transaction drops every entry and any outstanding write. A late `bvalid` after reset is ignored.
- Enqueue at edge t (buffer empty, FSM in IDLE): FSM enters ADDR at t+1, so `awvalid` is high in the cycle after t+1.
- Minimum throughput is one line per 3 cycles: IDLE, ADDR with immediate `awready`, then RESP with immediate `bvalid`.
- An enqueued entry is visible to snoop from the cycle after its enqueue edge. The head remains visible through the `bvalid` cycle and disappears after the pop edge.
- Simultaneous enqueue and pop: both take effect and occupancy is unchanged.
- When full, `wb_ready`=0 is derived from registered state. A pop in the same cycle does not raise `wb_ready` until the next cycle.
- Coalescing while full is not possible: `wb_ready` is low.

## Structure
- Shared package `wb_pkg`:
  - `ADDR_W`, `LINE_W`
  - `LINE_OFS`=3
  - Issue-state enum {IDLE, ADDR, RESP}
  - Entry struct {valid, addr tag, data}
- One sub-module, `wb_cam_fifo`: entry storage, pointers, full/empty, and match logic for both coalescing and snoop.
- `write_buffer` contains the issue FSM and the output registers.

## Test plan
- Reset, then write 0x0000_1008 / data 0xA5A5_A5A5_0000_0001 with `awready`=1 and `bvalid` one cycle after acceptance:
  - `awvalid` high for 1 cycle with `awaddr`=0x0000_1008, `wdata` as written.
  - `empty` returns to 1 three cycles after the enqueue edge.
- Hold `awready`=0 and enqueue 4 distinct lines:
  - `full`=1 and `wb_ready`=0.
  - `awaddr`/`wdata` stay on line 0 while `awready` is low.
  - Releasing `awready` drains the lines in FIFO order with wrap-around.
- Coalesce: with the head issued, write 0x2000 with data D1, then 0x2000 with data D2:
  - Occupancy stays at 2 (issued head plus one entry).
  - The second memory write carries D2.
- Snoop 0x0000_2004 while line 0x2000 is pending:
  - `snoop_hit`=1 and `snoop_data` matches the pending entry.
  - After its `bvalid` pop, `snoop_hit`=0 and `snoop_data`=0.
- Assert `rst` while in ADDR, then pulse `bvalid`:
  - All outputs take their reset values.
  - `bvalid` has no effect and `empty`=1.
